// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, request/response structs.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

package mdu_pkg;

  localparam int MDU_DATA_W = 32;
  localparam int MDU_TAG_W  = `ROB_WIDTH;

  // Multiply op codes follow the RISC-V funct3 numbering; 4..7 are unused
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3
  } mdu_mul_op_e;

  typedef struct packed {
    mdu_mul_op_e             op;
    logic [MDU_DATA_W-1:0]   data0;
    logic [MDU_DATA_W-1:0]   data1;
    logic [MDU_TAG_W-1:0]    tag;
  } mdu_mul_req_t;

  typedef struct packed {
    logic [MDU_DATA_W-1:0]   result;
    logic [MDU_TAG_W-1:0]    tag;
  } mdu_mul_rsp_t;

  // Operand signedness for an op: {data0 signed, data1 signed}
  function automatic logic [1:0] mdu_mul_signs(input logic [2:0] op);
    case (op)
      MDU_MUL, MDU_MULH: mdu_mul_signs = 2'b11;
      MDU_MULHSU:        mdu_mul_signs = 2'b10;
      default:           mdu_mul_signs = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mdu_mul_core.sv
// Multiply datapath: registered extended operands, then product carried through STAGES-1 slots.
// Latency: STAGES loads from operand capture to prod_o, each slot advancing on its ld_i bit.
// Backpressure: none internally; a slot holds whenever its ld_i bit is low.
module mdu_mul_core #(
  parameter int DATA_W = 32,
  parameter int STAGES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STAGES-1:0]     ld_i,
  input  logic [DATA_W:0]       a_i,
  input  logic [DATA_W:0]       b_i,
  output logic [2*DATA_W-1:0]   prod_o
);

  localparam int PW = 2 * DATA_W;

  logic signed [DATA_W:0] a_q, a_d, b_q, b_d;
  logic signed [PW-1:0]   a_x, b_x;
  (* use_dsp = "yes" *) logic [PW-1:0] prod_q [1:STAGES-1];
  logic [PW-1:0]          prod_d [1:STAGES-1];

  // Operand slot: capture the already sign/zero-extended operands on acceptance
  always_comb begin
    a_d = ld_i[0] ? a_i : a_q;
    b_d = ld_i[0] ? b_i : b_q;
  end

  // Product slots: the upper extension bits only replicate bit DATA_W, so this is
  // still a (DATA_W+1)x(DATA_W+1) signed multiply truncated to 2*DATA_W bits
  always_comb begin
    a_x = {{(DATA_W-1){a_q[DATA_W]}}, a_q};
    b_x = {{(DATA_W-1){b_q[DATA_W]}}, b_q};
    prod_d[1] = ld_i[1] ? a_x * b_x : prod_q[1];
    for (int k = 2; k < STAGES; k++) begin
      prod_d[k] = ld_i[k] ? prod_q[k-1] : prod_q[k];
    end
  end

  // Datapath registers; cleared on reset so the selected result reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      for (int k = 1; k < STAGES; k++) prod_q[k] <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      for (int k = 1; k < STAGES; k++) prod_q[k] <= prod_d[k];
    end
  end

  assign prod_o = prod_q[STAGES-1];

endmodule

// File: rtl/mdu_mul_pipe.sv
// Pipelined MUL/MULH/MULHSU/MULHU unit with per-slot valids and bubble collapsing.
// Latency: STAGES cycles unstalled (STAGES+1 for an op parked in the skid entry).
// Backpressure: valid/ready both sides; MDU_MUL_SKID_EN adds a 1-entry skid so ready_o is registered.
`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

module mdu_mul_pipe
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = `ROB_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [TAG_W-1:0]  tag_o
);

  typedef struct packed {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } meta_t;

  meta_t               meta_q [STAGES];
  meta_t               meta_d [STAGES];
  logic [STAGES-1:0]   vld_q, vld_d, free, ld;
  logic                chain;
  logic                accept, src_vld;
  meta_t               src_meta;
  logic [DATA_W-1:0]   src_d0, src_d1;
  logic [1:0]          signs;
  logic [DATA_W:0]     a_ext, b_ext;
  logic [2*DATA_W-1:0] prod;

  assign accept = valid_i && ready_o;

`ifdef MDU_MUL_SKID_EN
  logic              skid_vld_q, skid_vld_d;
  meta_t             skid_meta_q, skid_meta_d;
  logic [DATA_W-1:0] skid_d0_q, skid_d0_d, skid_d1_q, skid_d1_d;

  // ready_o comes from a flop; rst_n/flush only mask it, ready_i never reaches it
  assign ready_o  = rst_n && !flush && !skid_vld_q;
  assign src_vld  = skid_vld_q || accept;
  assign src_meta = skid_vld_q ? skid_meta_q : meta_t'{op: op_i, tag: tag_i};
  assign src_d0   = skid_vld_q ? skid_d0_q : data0_i;
  assign src_d1   = skid_vld_q ? skid_d1_q : data1_i;

  // Skid entry: park an accepted op when slot 0 cannot take it, drain when it can
  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_meta_d = skid_meta_q;
    skid_d0_d   = skid_d0_q;
    skid_d1_d   = skid_d1_q;
    if (flush) begin
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (free[0]) skid_vld_d = 1'b0;
    end else if (accept && !free[0]) begin
      skid_vld_d  = 1'b1;
      skid_meta_d = meta_t'{op: op_i, tag: tag_i};
      skid_d0_d   = data0_i;
      skid_d1_d   = data1_i;
    end
  end

  // Skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld_q  <= 1'b0;
      skid_meta_q <= '0;
      skid_d0_q   <= '0;
      skid_d1_q   <= '0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_meta_q <= skid_meta_d;
      skid_d0_q   <= skid_d0_d;
      skid_d1_q   <= skid_d1_d;
    end
  end
`else
  assign ready_o  = rst_n && !flush && free[0];
  assign src_vld  = accept;
  assign src_meta = meta_t'{op: op_i, tag: tag_i};
  assign src_d0   = data0_i;
  assign src_d1   = data1_i;
`endif

  // Slot k can take new content if it is empty or everything downstream moves
  always_comb begin
    chain = ready_i;
    free  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain   = !vld_q[k] || chain;
      free[k] = chain;
    end
  end

  // Data load enables: only load a slot when a valid op arrives into it
  always_comb begin
    ld[0] = free[0] && src_vld;
    for (int k = 1; k < STAGES; k++) ld[k] = free[k] && vld_q[k-1];
  end

  // Valid/meta next state; flush wipes every valid bit at the next edge
  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < STAGES; k++) meta_d[k] = meta_q[k];
    if (free[0]) vld_d[0] = src_vld;
    if (ld[0])   meta_d[0] = src_meta;
    for (int k = 1; k < STAGES; k++) begin
      if (free[k]) vld_d[k] = vld_q[k-1];
      if (ld[k])   meta_d[k] = meta_q[k-1];
    end
    if (flush) vld_d = '0;
  end

  // Slot valid and meta registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) meta_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) meta_q[k] <= meta_d[k];
    end
  end

  assign signs = mdu_mul_signs(src_meta.op);
  assign a_ext = {signs[1] & src_d0[DATA_W-1], src_d0};
  assign b_ext = {signs[0] & src_d1[DATA_W-1], src_d1};

  mdu_mul_core #(
    .DATA_W (DATA_W),
    .STAGES (STAGES)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_i   (ld),
    .a_i    (a_ext),
    .b_i    (b_ext),
    .prod_o (prod)
  );

  assign valid_o = vld_q[STAGES-1];
  assign tag_o   = meta_q[STAGES-1].tag;

  // Result half select; unknown ops yield zero
  always_comb begin
    result_o = '0;
    case (meta_q[STAGES-1].op)
      MDU_MUL:                         result_o = prod[DATA_W-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: result_o = prod[2*DATA_W-1:DATA_W];
      default:                         result_o = '0;
    endcase
  end

endmodule

// File: doc/mdu_mul_pipe.md
MDU_MUL_PIPE -- requirements
Module: mdu_mul_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter STAGES, default 3, range 2..6, unstalled latency in cycles.
REQ-003 SHALL have parameter TAG_W, default `ROB_WIDTH, writeback tag width.
REQ-004 SHALL have port clk  in  1  sole clock; rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  in  1  kill all in-flight ops.
REQ-007 SHALL have port valid_i  in  1  request valid.
REQ-008 SHALL have port ready_o  out  1  request accepted when valid_i&&ready_o.
REQ-009 SHALL have port op_i  in  3  MUL/MULH/MULHU/MULHSU code.
REQ-010 SHALL have ports data0_i, data1_i  in  DATA_W  operands (rs1, rs2).
REQ-011 SHALL have port tag_i  in  TAG_W  destination tag.
REQ-012 SHALL have port valid_o  out  1  result valid.
REQ-013 SHALL have port ready_i  in  1  consumer ready; transfer on valid_o&&ready_i.
REQ-014 SHALL have ports result_o  out  DATA_W, tag_o  out  TAG_W.

Function
REQ-015 SHALL extend each operand to DATA_W+1 bits: sign bit for signed operands, zero for unsigned; MUL/MULH both signed, MULHU both unsigned, MULHSU data0 signed/data1 unsigned.
REQ-016 SHALL form a 2*DATA_W-bit signed product; MUL returns bits [DATA_W-1:0], MULH/MULHU/MULHSU return [2*DATA_W-1:DATA_W]; unknown op returns 0.
REQ-017 SHALL have STAGES pipeline slots, each with its own valid bit; op and tag travel with the data.
REQ-018 SHALL present result STAGES cycles after acceptance when never stalled; throughput one op/cycle.
REQ-019 SHALL advance slot k when slot k+1 is empty or advancing (bubble collapsing); last slot advances on ready_i.
REQ-020 SHALL drive ready_o = !flush && (slot 1 empty || slot 1 advancing), no-skid build.
REQ-021 SHALL hold result_o/tag_o/valid_o stable while valid_o && !ready_i.
REQ-022 SHALL on flush clear every valid bit at the next edge; a request presented in a flush cycle is not accepted; output transfer in the flush cycle is still completed if ready_i.
REQ-023 SHALL keep op order; no reordering, no drop except by flush.
REQ-024 SHALL compute results from the operand values at acceptance, independent of later input changes.

Reset
REQ-025 SHALL, while rst_n=0, force all valid bits, valid_o, result_o, tag_o and skid state to 0; ready_o=0 during reset.
REQ-026 SHALL accept a request on the first edge after rst_n deasserts; in-flight ops at reset are discarded.

Configuration
REQ-027 SHALL provide macro MDU_MUL_SKID_EN.
REQ-028 With MDU_MUL_SKID_EN defined SHALL add a 1-entry input skid buffer; ready_o is a register output = skid empty, no combinational path from ready_i; latency STAGES when skid empty, STAGES+1 for an op taken into skid; flush also empties skid.
REQ-029 Without MDU_MUL_SKID_EN SHALL implement REQ-020 exactly, no skid storage.

Structure
REQ-030 SHALL place op codes (including new MULHSU), request/response structs mdu_mul_req_t/mdu_mul_rsp_t in shared package mdu_pkg.
REQ-031 SHALL use one sub-module mdu_mul_core: registered signed (DATA_W+1)x(DATA_W+1) multiply with DSP inference attribute, retimed over STAGES-1 slots.
REQ-032 SHALL contain no latches; all state updated in one async-reset sequential block per register group.

Verification
REQ-033 SHALL cover: MUL 0x0000_0007 x 0xFFFF_FFFD, tag 5 -> result 0xFFFF_FFEB, tag 5, valid_o exactly 3 cycles after accept.
REQ-034 SHALL cover: MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000; MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE; MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF.
REQ-035 SHALL cover: 8 back-to-back ops tags 0..7, ready_i low cycles 4-7 -> no loss, in-order tags, ready_o low only once pipe full, outputs stable while stalled.
REQ-036 SHALL cover: flush with 3 ops in flight plus valid_i high same cycle -> no valid_o from those ops, next op accepted after flush returns result after 3 cycles.
REQ-037 SHALL cover: rst_n pulled low mid-stream for 1 cycle asynchronously -> valid_o=0, result_o=0 immediately, no stale result afterwards.
REQ-038 SHALL cover with MDU_MUL_SKID_EN: ready_i low at full pipe -> one extra op captured in skid, ready_o falls the following cycle, all ops delivered in order.
